// File: rtl/uart_route_hub_pkg.sv
// uart_hub_pkg: FSM state type and sizing helpers shared by the UART route hub
package uart_hub_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, WAIT, ISSUE} state_e;
  localparam int SRC_W = 4;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int inj_src(input int n);
    return n;
  endfunction
endpackage

// File: rtl/uart_route_hub_byte_fifo.sv
// byte_fifo: synchronous FIFO with extra-MSB wrap pointers; drop pulses when a push is refused
module byte_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic full, do_push, do_pop;
  always_comb begin
    empty   = rptr_q == wptr_q;
    full    = (rptr_q[AW] != wptr_q[AW]) && (rptr_q[AW-1:0] == wptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    drop    = push && !do_push;
    wptr_d  = wptr_q + (AW+1)'(do_push);
    rptr_d  = rptr_q + (AW+1)'(do_pop);
    rdata   = mem_q[rptr_q[AW-1:0]];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/uart_route_hub.sv
// uart_route_hub: round-robin byte router from UART rx FIFOs and a local inject source to masked uart_tx channels
module uart_route_hub
  import uart_hub_pkg::*;
#(
  parameter int                    N_CH  = 2,
  parameter int                    W     = 8,
  parameter int                    DEPTH = 4,
  parameter logic [N_CH*N_CH-1:0]  ROUTE = 4'b0111,
  parameter int                    GUARD = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_CH-1:0]     rx_done,
  input  logic [N_CH*W-1:0]   rx_data,
  input  logic                inj_req,
  input  logic [W-1:0]        inj_data,
  input  logic [N_CH-1:0]     tx_busy,
  output logic [N_CH-1:0]     tx_start,
  output logic [N_CH*W-1:0]   tx_data,
  output logic [W-1:0]        last_data,
  output logic [SRC_W-1:0]    last_src,
  output logic                last_valid,
  output logic [N_CH-1:0]     ovf,
  input  logic                ovf_clr
);
  localparam int PW = ptr_w(N_CH);
  localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  state_e                      state_q, state_d;
  logic [N_CH-1:0]             rx_prev_q, rx_rise, pop, fifo_empty, fifo_drop, guard_nz;
  logic                        inj_prev_q, inj_rise, inj_full_q, inj_full_d, inj_clear;
  logic [W-1:0]                inj_byte_q, inj_byte_d, byte_q, byte_d;
  logic [W-1:0]                fifo_rdata [N_CH];
  logic [PW-1:0]               rr_q, rr_d, sel_q, sel_d, pick, idx;
  logic                        sel_inj_q, sel_inj_d, found, wait_busy;
  logic [N_CH-1:0]             dmask_q, dmask_d, tx_start_q, tx_start_d, ovf_q, ovf_d;
  logic [N_CH*W-1:0]           tx_data_q, tx_data_d;
  logic [W-1:0]                last_data_q, last_data_d;
  logic [SRC_W-1:0]            last_src_q, last_src_d;
  logic                        last_valid_q, last_valid_d;
  logic [N_CH-1:0][GW-1:0]     guard_q, guard_d;
  int                          scan_idx;

  assign rx_rise  = rx_done & ~rx_prev_q;
  assign inj_rise = inj_req & ~inj_prev_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_fifo
    byte_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .reset_n(reset_n),
      .push   (rx_rise[i]),
      .pop    (pop[i]),
      .wdata  (rx_data[i*W +: W]),
      .rdata  (fifo_rdata[i]),
      .empty  (fifo_empty[i]),
      .drop   (fifo_drop[i])
    );
    assign guard_nz[i] = |guard_q[i];
  end

  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = 0;
    idx      = '0;
    for (int k = 0; k < N_CH; k++) begin
      scan_idx = (int'(rr_q) + k) % N_CH;
      idx      = PW'(scan_idx);
      if (!found && !fifo_empty[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign wait_busy = |(dmask_q & (tx_busy | guard_nz));

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    sel_d        = sel_q;
    sel_inj_d    = sel_inj_q;
    byte_d       = byte_q;
    dmask_d      = dmask_q;
    tx_start_d   = '0;
    tx_data_d    = tx_data_q;
    last_data_d  = last_data_q;
    last_src_d   = last_src_q;
    last_valid_d = 1'b0;
    pop          = '0;
    inj_clear    = 1'b0;
    for (int j = 0; j < N_CH; j++) guard_d[j] = guard_nz[j] ? guard_q[j] - 1'b1 : '0;
    case (state_q)
      IDLE: begin
        if (inj_full_q || found) state_d = GRANT;
        sel_inj_d = inj_full_q;
        sel_d     = inj_full_q ? sel_q : pick;
      end
      GRANT: begin
        state_d = WAIT;
        if (sel_inj_q) begin
          byte_d    = inj_byte_q;
          dmask_d   = '1;
          inj_clear = 1'b1;
        end else begin
          pop[sel_q] = 1'b1;
          byte_d     = fifo_rdata[sel_q];
          dmask_d    = ROUTE[int'(sel_q)*N_CH +: N_CH];
          rr_d       = (int'(sel_q) == N_CH - 1) ? '0 : sel_q + 1'b1;
        end
      end
      WAIT: begin
        if (!wait_busy) begin
          state_d      = ISSUE;
          tx_start_d   = dmask_q;
          last_data_d  = byte_q;
          last_src_d   = sel_inj_q ? SRC_W'(inj_src(N_CH)) : SRC_W'(sel_q);
          last_valid_d = 1'b1;
          for (int j = 0; j < N_CH; j++) begin
            if (dmask_q[j]) begin
              tx_data_d[j*W +: W] = byte_q;
              guard_d[j]          = GW'(GUARD);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inj_full_d = inj_full_q && !inj_clear;
    inj_byte_d = inj_byte_q;
    if (inj_rise && !inj_full_q) begin
      inj_full_d = 1'b1;
      inj_byte_d = inj_data;
    end
    ovf_d = (ovf_q & ~{N_CH{ovf_clr}}) | fifo_drop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rx_prev_q    <= '0;
      inj_prev_q   <= 1'b0;
      inj_full_q   <= 1'b0;
      inj_byte_q   <= '0;
      rr_q         <= '0;
      sel_q        <= '0;
      sel_inj_q    <= 1'b0;
      byte_q       <= '0;
      dmask_q      <= '0;
      tx_start_q   <= '0;
      tx_data_q    <= '0;
      last_data_q  <= '0;
      last_src_q   <= '0;
      last_valid_q <= 1'b0;
      ovf_q        <= '0;
      guard_q      <= '0;
    end else begin
      state_q      <= state_d;
      rx_prev_q    <= rx_done;
      inj_prev_q   <= inj_req;
      inj_full_q   <= inj_full_d;
      inj_byte_q   <= inj_byte_d;
      rr_q         <= rr_d;
      sel_q        <= sel_d;
      sel_inj_q    <= sel_inj_d;
      byte_q       <= byte_d;
      dmask_q      <= dmask_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      last_data_q  <= last_data_d;
      last_src_q   <= last_src_d;
      last_valid_q <= last_valid_d;
      ovf_q        <= ovf_d;
      guard_q      <= guard_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign last_data  = last_data_q;
  assign last_src   = last_src_q;
  assign last_valid = last_valid_q;
  assign ovf        = ovf_q;
endmodule

// File: tb/tb_uart_route_hub.sv
// tb_uart_route_hub: directed self-checking bench for the two-channel default hub configuration
module tb_uart_route_hub;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  rx_done = '0;
  logic [15:0] rx_data = '0;
  logic        inj_req = 1'b0;
  logic [7:0]  inj_data = '0;
  logic [1:0]  tx_busy = '0;
  logic        ovf_clr = 1'b0;
  logic [1:0]  tx_start;
  logic [15:0] tx_data;
  logic [7:0]  last_data;
  logic [3:0]  last_src;
  logic        last_valid;
  logic [1:0]  ovf;
  int checks = 0;
  int errors = 0;
  int gap;

  uart_route_hub dut (
    .clk(clk), .reset_n(reset_n), .rx_done(rx_done), .rx_data(rx_data),
    .inj_req(inj_req), .inj_data(inj_data), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .last_data(last_data),
    .last_src(last_src), .last_valid(last_valid), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] m, input logic [7:0] d0, input logic [7:0] d1);
    rx_data = {d1, d0};
    rx_done = m;
    tick();
    rx_done = 2'b00;
    tick();
  endtask

  task automatic wait_start(input string tag, input logic [1:0] m, input logic [15:0] d,
                            input logic [7:0] b, input logic [3:0] s, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (tx_start === 2'b00 && n < 40);
    chk({tag, " tx_start"}, 32'(tx_start), 32'(m));
    chk({tag, " tx_data"}, 32'(tx_data), 32'(d));
    chk({tag, " last_data"}, 32'(last_data), 32'(b));
    chk({tag, " last_src"}, 32'(last_src), 32'(s));
    chk({tag, " last_valid"}, 32'(last_valid), 32'd1);
  endtask

  task automatic quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk(tag, 32'(tx_start), 32'd0);
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst tx_start", 32'(tx_start), 32'd0);
    chk("rst tx_data", 32'(tx_data), 32'd0);
    chk("rst last", 32'({last_data, last_src, last_valid}), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    reset_n = 1'b1;
    tick();
    rx_data = 16'h0041;
    rx_done = 2'b01;
    tick();
    tick();
    chk("lat k+1", 32'(tx_start), 32'd0);
    tick();
    chk("lat k+2", 32'(tx_start), 32'd0);
    tick();
    chk("lat k+3 tx_start", 32'(tx_start), 32'h3);
    chk("lat k+3 tx_data", 32'(tx_data), 32'h4141);
    chk("lat k+3 last_data", 32'(last_data), 32'h41);
    chk("lat k+3 last_src", 32'(last_src), 32'd0);
    chk("lat k+3 last_valid", 32'(last_valid), 32'd1);
    tick();
    chk("lat k+4 tx_start", 32'(tx_start), 32'd0);
    chk("lat k+4 last_valid", 32'(last_valid), 32'd0);
    rx_done = 2'b00;
    tick();
    push(2'b10, 8'h00, 8'h5A);
    wait_start("ch1 route", 2'b01, 16'h415A, 8'h5A, 4'd1, gap);
    push(2'b11, 8'h10, 8'h20);
    wait_start("rr0 first", 2'b11, 16'h1010, 8'h10, 4'd0, gap);
    wait_start("rr0 second", 2'b01, 16'h1020, 8'h20, 4'd1, gap);
    chk("rr0 spacing", 32'(gap), 32'd4);
    push(2'b01, 8'h33, 8'h00);
    wait_start("rr setup", 2'b11, 16'h3333, 8'h33, 4'd0, gap);
    push(2'b11, 8'h10, 8'h20);
    wait_start("rr1 first", 2'b01, 16'h3320, 8'h20, 4'd1, gap);
    wait_start("rr1 second", 2'b11, 16'h1010, 8'h10, 4'd0, gap);
    chk("rr1 spacing", 32'(gap), 32'd4);
    tx_busy = 2'b01;
    push(2'b10, 8'h00, 8'h77);
    for (int i = 0; i < 5; i++) begin
      push(2'b01, 8'hA0 + 8'(i), 8'h77);
      chk("busy hold", 32'(tx_start), 32'd0);
      chk("ovf fill", 32'(ovf), (i == 4) ? 32'h1 : 32'h0);
    end
    rx_data = 16'h00A5;
    rx_done = 2'b01;
    ovf_clr = 1'b1;
    tick();
    rx_done = 2'b00;
    ovf_clr = 1'b0;
    chk("ovf_clr vs new ovf", 32'(ovf), 32'h1);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'h0);
    quiet("busy quiet", 6);
    tx_busy = 2'b00;
    wait_start("drain ch1", 2'b01, 16'h1077, 8'h77, 4'd1, gap);
    wait_start("drain A0", 2'b11, 16'hA0A0, 8'hA0, 4'd0, gap);
    wait_start("drain A1", 2'b11, 16'hA1A1, 8'hA1, 4'd0, gap);
    wait_start("drain A2", 2'b11, 16'hA2A2, 8'hA2, 4'd0, gap);
    wait_start("drain A3", 2'b11, 16'hA3A3, 8'hA3, 4'd0, gap);
    chk("drain spacing", 32'(gap), 32'd4);
    quiet("no dropped byte", 12);
    chk("ovf after drain", 32'(ovf), 32'h0);
    tx_busy = 2'b01;
    push(2'b10, 8'h00, 8'h55);
    push(2'b01, 8'h66, 8'h00);
    inj_data = 8'hC3;
    inj_req = 1'b1;
    tick();
    inj_req = 1'b0;
    tick();
    inj_data = 8'hEE;
    inj_req = 1'b1;
    tick();
    inj_req = 1'b0;
    tick();
    tx_busy = 2'b00;
    wait_start("inj pre ch1", 2'b01, 16'hA355, 8'h55, 4'd1, gap);
    wait_start("inject", 2'b11, 16'hC3C3, 8'hC3, 4'd2, gap);
    wait_start("after inject ch0", 2'b11, 16'h6666, 8'h66, 4'd0, gap);
    quiet("second inject dropped", 12);
    tx_busy = 2'b01;
    push(2'b01, 8'h99, 8'h00);
    push(2'b11, 8'h98, 8'h97);
    reset_n = 1'b0;
    #1;
    chk("async rst tx_data", 32'(tx_data), 32'd0);
    tick();
    chk("rst wait tx_start", 32'(tx_start), 32'd0);
    chk("rst wait last", 32'({last_data, last_src, last_valid}), 32'd0);
    chk("rst wait ovf", 32'(ovf), 32'd0);
    tx_busy = 2'b00;
    reset_n = 1'b1;
    quiet("post rst quiet", 15);
    push(2'b10, 8'h00, 8'h12);
    wait_start("post rst route", 2'b01, 16'h0012, 8'h12, 4'd1, gap);
    quiet("post rst fifos empty", 10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_route_hub.md
Name: uart_route_hub

Overview:
- Parametrised N-channel byte router between UART endpoints: PC/keyboard UART, inter-board UART links, and a local switch-injection source.
- Each receive channel feeds a per-channel byte FIFO. A round-robin arbiter forwards each byte to a per-source destination mask of uart_tx instances.
- The hub also reports the last routed byte to the display path (seven-seg/VGA write).
- Sits between the uart_rx/uart_tx instances and the display logic in the system top, on the baud-tick clock domain.

Parameters:
- N_CH, 2, number of UART channels (2..8).
- W, 8, byte width.
- DEPTH, 4, per-channel FIFO depth; power of 2, at least 2.
- ROUTE, 4'b0111, N_CH*N_CH destination masks; bits [i*N_CH +: N_CH] give the destinations of source i.
  - Default: ch0 → {0,1}; ch1 → {0}.
- GUARD, 2, cycles after tx_start during which tx_busy of that channel is ignored and the channel is treated as busy.

Ports:
- clk  in  1  hub clock (baud-tick domain).
- reset_n  in  1  asynchronous active-low reset.
- rx_done  in  N_CH  per-channel uart_rx "received" level; a rising edge means a new byte.
- rx_data  in  N_CH*W  per-channel received byte; valid at the rx_done rising edge.
- inj_req  in  1  local inject request (debounced button level).
- inj_data  in  W  byte to inject (switches).
- tx_busy  in  N_CH  per-channel transmitter busy.
- tx_start  out  N_CH  one-cycle start pulse per destination channel.
- tx_data  out  N_CH*W  byte for each transmitter; held stable until the next tx_start on that channel.
- last_data  out  W  last routed byte.
- last_src  out  4  source of last_data (0..N_CH-1, or N_CH for inject).
- last_valid  out  1  one-cycle pulse when last_data/last_src update.
- ovf  out  N_CH  sticky FIFO-overflow flags.
- ovf_clr  in  1  clears all ovf flags.

Behaviour:
- Reset values: all outputs 0, FIFOs empty, inject holder empty, RR pointer 0, FSM IDLE, guard counters 0. Reset mid-transfer discards all in-flight bytes; no tx_start is issued after reset release until new input arrives.
- Edge detection: each rx_done and inj_req is registered. A rise (prev 0, now 1) at edge k pushes rx_data[i] into FIFO i, or inj_data into the inject holder, at edge k.
- FIFO full on push: byte dropped and ovf[i] set. Push and pop on the same edge to the same FIFO are both legal and leave the count unchanged.
- Inject holder already full on a new inj_req rise: the new request is dropped (no flag).
- ovf_clr: clears ovf. A simultaneous new overflow wins (flag stays 1).
- FSM states are IDLE, GRANT, WAIT and ISSUE.
  - IDLE: if the inject holder is full, select inject (priority). Otherwise scan FIFOs from the RR pointer and select the first non-empty one. Go to GRANT if anything is selected.
  - GRANT: pop the selected source; latch the byte, the source, and dmask = ROUTE row (inject: all ones). Advance the RR pointer to (src+1) mod N_CH; inject does not advance it.
  - WAIT: stay while any dmask channel is busy (tx_busy or guard counter ≠ 0). Otherwise go to ISSUE.
  - ISSUE: for one cycle, tx_start = dmask, tx_data[j] = byte for every j in dmask, and last_valid = 1 with last_data/last_src updated. Load each dmask channel's guard counter with GUARD. Return to IDLE.
- Latency: a push at edge k with everything idle produces tx_start high in the cycle after edge k+3. Sustained throughput is one byte per 4 cycles.
- Empty dmask: no tx_start is issued; last_valid still pulses.
- Guard counters decrement to 0 and saturate there.

Decomposition:
- Package uart_hub_pkg: FSM state enum, clog2-based pointer width constant, inject source id constant (N_CH).
- Sub-module byte_fifo (W, DEPTH): synchronous FIFO with full/empty flags and wrap-around pointers plus an extra MSB; instantiated N_CH times.
- Edge detectors and the arbiter are inline.

Test Plan:
- Reset, then rx_done[0] rise with 8'h41, all tx idle: tx_start = 2'b11 in the cycle after edge k+3, tx_data both 8'h41, last_src = 0, last_valid one pulse.
- rx_done[1] rise with 8'h5A: tx_start = 2'b01 only; tx_data[1] unchanged.
- Both channels rise on the same edge (0x10 on ch0, 0x20 on ch1), RR pointer 0: 0x10 issued first, then 0x20 four cycles later. Repeating with pointer 1 reverses the order.
- tx_busy[0] held high for 20 cycles, then 5 bytes pushed on ch0 with DEPTH = 4: the 5th byte is dropped and ovf[0] = 1. After busy falls, exactly 4 bytes go out in order. ovf_clr clears the flag.
- inj_req rise with sw = 8'hC3 while FIFO0 is non-empty: inject is served first, tx_start = 2'b11, last_src = 2. A second inj_req before it is served is dropped.
- Assert reset_n low while in WAIT: tx_start stays 0, FIFOs are empty, and no pending byte is transmitted after reset release.
